// File: rtl/lcd_window_fetch_ctrl.sv
// lcd_window_fetch_ctrl: 800x480 panel timing plus windowed image fetch.
// Panel outputs are delayed to line up with the image memory read latency.
module lcd_window_fetch_ctrl #(
    parameter int H_ACTIVE = 800,
    parameter int H_BP     = 46,
    parameter int H_FP     = 210,
    parameter int H_PULSE  = 1,
    parameter int V_ACTIVE = 480,
    parameter int V_BP     = 0,
    parameter int V_FP     = 45,
    parameter int V_PULSE  = 5,
    parameter int IMG_W    = 390,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int MEM_LAT  = 2
) (
    input  logic              PixelClk,
    input  logic              Reset,
    input  logic              cfg_valid,
    input  logic [9:0]        cfg_x0,
    input  logic [9:0]        cfg_y0,
    output logic              cfg_ready,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    output logic              LCD_DE,
    output logic              LCD_HSYNC,
    output logic              LCD_VSYNC,
    output logic [4:0]        LCD_R,
    output logic [5:0]        LCD_G,
    output logic [4:0]        LCD_B,
    output logic              frame_start
);

    localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [9:0] X0_MAX = 10'(H_ACTIVE - IMG_W);
    localparam logic [9:0] Y0_MAX = 10'(V_ACTIVE - IMG_H);
    localparam logic [9:0] X0_RST = 10'((H_ACTIVE - IMG_W) / 2);
    localparam logic [9:0] Y0_RST = 10'((V_ACTIVE - IMG_H) / 2);

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic de;
        logic win;
        logic sof;
    } tmg_t;

    localparam tmg_t TMG_IDLE = '{
        hs_n: 1'b1,
        vs_n: 1'b1,
        de:   1'b0,
        win:  1'b0,
        sof:  1'b0
    };

    logic [HCW-1:0]    h_cnt;
    logic [VCW-1:0]    v_cnt;
    logic              h_wrap;
    logic              v_last;
    logic              f_wrap;
    logic              l_wrap;

    logic [9:0]        x0;
    logic [9:0]        y0;
    logic [9:0]        sh_x;
    logic [9:0]        sh_y;
    logic              sh_full;

    logic [HCW-1:0]    x_lo;
    logic [HCW-1:0]    x_hi;
    logic [VCW-1:0]    y_lo;
    logic [VCW-1:0]    y_hi;
    logic              h_act;
    logic              v_act;
    tmg_t              tmg;

    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] col;

    tmg_t              tmg_d [0:MEM_LAT];
    tmg_t              tq;

    logic              unused_dout;

    assign h_wrap = h_cnt == HCW'(H_TOTAL - 1);
    assign v_last = v_cnt == VCW'(V_TOTAL - 1);
    assign f_wrap = h_wrap && v_last;
    assign l_wrap = h_wrap && !v_last;

    assign cfg_ready   = ~sh_full;
    assign tq          = tmg_d[MEM_LAT];
    assign unused_dout = ^mem_dout[1:0];

    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // x0/y0 are always clamped, so the window bounds fit the counter widths.
    always_comb begin
        x_lo     = HCW'(H_BP) + HCW'(x0);
        x_hi     = x_lo + HCW'(IMG_W);
        y_lo     = VCW'(V_BP) + VCW'(y0);
        y_hi     = y_lo + VCW'(IMG_H);
        h_act    = (h_cnt >= HCW'(H_BP)) &&
                   (h_cnt < HCW'(H_BP + H_ACTIVE));
        v_act    = (v_cnt >= VCW'(V_BP)) &&
                   (v_cnt < VCW'(V_BP + V_ACTIVE));
        tmg      = TMG_IDLE;
        tmg.hs_n = h_cnt >= HCW'(H_PULSE);
        tmg.vs_n = v_cnt >= VCW'(V_PULSE);
        tmg.de   = h_act && v_act;
        tmg.win  = tmg.de &&
                   (h_cnt >= x_lo) && (h_cnt < x_hi) &&
                   (v_cnt >= y_lo) && (v_cnt < y_hi);
        tmg.sof  = (h_cnt == '0) && (v_cnt == '0);
    end

    // A shadowed position only takes effect on the frame wrap.
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            sh_full <= 1'b0;
            sh_x    <= '0;
            sh_y    <= '0;
            x0      <= X0_RST;
            y0      <= Y0_RST;
        end else if (f_wrap && sh_full) begin
            x0      <= sh_x;
            y0      <= sh_y;
            sh_full <= 1'b0;
        end else if (cfg_valid && !sh_full) begin
            sh_full <= 1'b1;
            sh_x    <= (cfg_x0 > X0_MAX) ? X0_MAX : cfg_x0;
            sh_y    <= (cfg_y0 > Y0_MAX) ? Y0_MAX : cfg_y0;
        end
    end

    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            mem_ce    <= 1'b0;
            mem_addr  <= '0;
            line_base <= '0;
            col       <= '0;
        end else begin
            mem_ce <= tmg.win;
            if (tmg.win) begin
                mem_addr <= line_base + col;
                col      <= col + 1'b1;
            end
            if (h_wrap) begin
                col <= '0;
            end
            unique case (1'b1)
                f_wrap: line_base <= '0;
                l_wrap: begin
                    if (col != '0) begin
                        line_base <= line_base + ADDR_W'(IMG_W);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                tmg_d[i] <= TMG_IDLE;
            end
        end else begin
            tmg_d[0] <= tmg;
            for (int i = 1; i <= MEM_LAT; i++) begin
                tmg_d[i] <= tmg_d[i-1];
            end
        end
    end

    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            LCD_DE      <= 1'b0;
            LCD_HSYNC   <= 1'b1;
            LCD_VSYNC   <= 1'b1;
            LCD_R       <= '0;
            LCD_G       <= '0;
            LCD_B       <= '0;
            frame_start <= 1'b0;
        end else begin
            LCD_DE      <= tq.de;
            LCD_HSYNC   <= tq.hs_n;
            LCD_VSYNC   <= tq.vs_n;
            LCD_R       <= tq.win ? mem_dout[7:3] : '0;
            LCD_G       <= tq.win ? mem_dout[7:2] : '0;
            LCD_B       <= tq.win ? mem_dout[7:3] : '0;
            frame_start <= tq.sof;
        end
    end

endmodule
